// File: rtl/csr_pipe_pkg.sv
// Shared types for the CSR read-modify-write pipeline: op codes, privilege levels, slot layout.
package csr_pipe_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    RW   = 3'd1,
    RS   = 3'd2,
    RC   = 3'd3,
    RWI  = 3'd4,
    RSI  = 3'd5,
    RCI  = 3'd6
  } csr_op_e;

  localparam logic [1:0] PRIV_U  = 2'd0;
  localparam logic [1:0] PRIV_S  = 2'd1;
  localparam logic [1:0] PRIV_M  = 2'd3;
  localparam logic [1:0] RO_BITS = 2'b11;

  // Widest supported XLEN; narrower instances use the low bits only.
  localparam int SLOT_DW = 64;

  typedef struct packed {
    logic               valid;
    logic [11:0]        waddr;
    logic [SLOT_DW-1:0] wdata;
  } slot_t;

  function automatic logic op_is_imm(input csr_op_e op);
    return (op == RWI) || (op == RSI) || (op == RCI);
  endfunction

endpackage

// File: rtl/csr_op_alu.sv
// Combinational CSR read-modify-write: new value and write-enable from op, old value and source.
module csr_op_alu
  import csr_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_no_src,
  output logic [XLEN-1:0] o_new,
  output logic            o_write
);

  always_comb begin
    o_new   = i_old;
    o_write = 1'b0;
    case (csr_op_e'(i_op))
      RW, RWI: begin
        o_new   = i_src;
        o_write = 1'b1;
      end
      // Set/clear with a zero source is a pure read and must not write.
      RS, RSI: begin
        o_new   = i_old | i_src;
        o_write = !i_no_src;
      end
      RC, RCI: begin
        o_new   = i_old & ~i_src;
        o_write = !i_no_src;
      end
      default: begin
        o_new   = i_old;
        o_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_bypass_pipe.sv
// CSR RMW pipeline with a DEPTH-slot in-flight write queue; reads forward from the youngest
// matching slot, results are registered one cycle after issue, writes commit from the last slot.
module csr_bypass_pipe
  import csr_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      priv,
  input  logic            in_valid,
  input  logic [2:0]      in_op,
  input  logic [11:0]     in_addr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [4:0]      in_zimm,
  input  logic            in_rs1_is_x0,
  input  logic            in_rd_is_x0,
  output logic [11:0]     file_raddr,
  input  logic [XLEN-1:0] file_rdata,
  output logic            file_wen,
  output logic [11:0]     file_waddr,
  output logic [XLEN-1:0] file_wdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_old,
  output logic            out_illegal
);

  csr_op_e         w_op;
  logic            w_imm;
  logic            w_issue;
  logic            w_no_src;
  logic            w_write;
  logic            w_illegal;
  logic            w_hold;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_unused;

  slot_t           r_slot [DEPTH];
  logic            r_out_valid;
  logic            r_out_illegal;
  logic [XLEN-1:0] r_out_old;

  assign w_op     = csr_op_e'(in_op);
  assign w_imm    = op_is_imm(w_op);
  assign w_issue  = in_valid && (w_op != NONE) && !stall && !flush;
  assign w_src    = w_imm ? XLEN'(in_zimm) : in_rs1;
  assign w_no_src = w_imm ? (in_zimm == 5'd0) : in_rs1_is_x0;
  assign w_hold   = stall && !flush;

  // Oldest slot is applied first so the youngest match overrides it.
  always_comb begin
    w_old = file_rdata;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_slot[k].valid && (r_slot[k].waddr == in_addr)) begin
        w_old = r_slot[k].wdata[XLEN-1:0];
      end
    end
  end

  csr_op_alu #(.XLEN(XLEN)) u_alu (
    .i_op     (in_op),
    .i_old    (w_old),
    .i_src    (w_src),
    .i_no_src (w_no_src),
    .o_new    (w_new),
    .o_write  (w_write)
  );

  assign w_illegal = (in_addr[9:8] > priv) || (w_write && (in_addr[11:10] == RO_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k].valid <= 1'b0;
      end
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_old     <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k].valid <= 1'b0;
      end
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_slot[k] <= r_slot[k-1];
      end
      r_slot[0].valid <= w_issue && w_write && !w_illegal;
      r_slot[0].waddr <= in_addr;
      r_slot[0].wdata <= SLOT_DW'(w_new);
      r_out_valid     <= w_issue;
      r_out_illegal   <= w_issue && w_illegal;
      if (w_issue) begin
        r_out_old <= w_illegal ? '0 : w_old;
      end
    end
  end

  // A flush edge still retires the last slot; only a plain stall or reset blocks the commit.
  assign file_wen    = r_slot[DEPTH-1].valid && !w_hold && !rst;
  assign file_waddr  = r_slot[DEPTH-1].waddr;
  assign file_wdata  = r_slot[DEPTH-1].wdata[XLEN-1:0];
  assign file_raddr  = in_addr;
  assign out_valid   = r_out_valid;
  assign out_old     = r_out_old;
  assign out_illegal = r_out_illegal;

  // rd=x0 only tags the result downstream; slot data above XLEN is never read.
  always_comb begin
    w_unused = in_rd_is_x0;
    for (int k = 0; k < DEPTH; k++) begin
      w_unused = w_unused ^ (^r_slot[k].wdata);
    end
  end

endmodule

// File: tb/tb_csr_bypass_pipe.sv
// Scoreboard bench: architectural model of CSR state plus an in-flight write list predicts results and commits.
module tb_csr_bypass_pipe;
  import csr_pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, stall, flush, in_valid, in_rs1_is_x0, in_rd_is_x0;
  logic [1:0]      priv;
  logic [2:0]      in_op;
  logic [11:0]     in_addr, file_raddr, file_waddr;
  logic [XLEN-1:0] in_rs1, file_rdata, file_wdata, out_old;
  logic [4:0]      in_zimm;
  logic            file_wen, out_valid, out_illegal;

  always #5 clk = ~clk;

  csr_bypass_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .priv(priv),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_rs1(in_rs1),
    .in_zimm(in_zimm), .in_rs1_is_x0(in_rs1_is_x0), .in_rd_is_x0(in_rd_is_x0),
    .file_raddr(file_raddr), .file_rdata(file_rdata), .file_wen(file_wen),
    .file_waddr(file_waddr), .file_wdata(file_wdata), .out_valid(out_valid),
    .out_old(out_old), .out_illegal(out_illegal)
  );

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return {a, 4'h5, a, 4'hA};
  endfunction

  // csr_file stand-in, written only by the DUT's commits
  logic [31:0] file_mem [4096];
  bit          file_written [4096];
  assign file_rdata = file_written[file_raddr] ? file_mem[file_raddr] : init_val(file_raddr);
  always @(posedge clk) begin
    if (file_wen === 1'b1) begin
      file_mem[file_waddr]     <= file_wdata;
      file_written[file_waddr] <= 1'b1;
    end
  end

  typedef struct { logic [11:0] addr; logic [31:0] data; int age; } pend_t;
  typedef struct { logic ill; logic [31:0] old; } out_t;
  typedef struct { logic [11:0] a; logic [31:0] d; } cmt_t;

  pend_t       pend[$];
  out_t        exp_out[$];
  cmt_t        exp_cmt[$];
  logic [31:0] ref_mem [4096];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // One cycle of stimulus; the model predicts what the edge closing this cycle produces.
  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                      input logic [4:0] z, input logic x0, input logic [1:0] pv);
    logic        hold, issue, imm, nosrc, wr, ill;
    logic [31:0] old, src, nv;
    @(posedge clk);
    #1;
    rst = r; stall = s; flush = f; in_valid = v; in_op = op; in_addr = a;
    in_rs1 = rs1; in_zimm = z; in_rs1_is_x0 = x0; priv = pv;
    in_rd_is_x0 = 1'($urandom_range(0, 1));
    if (r) begin
      pend.delete();
      return;
    end
    hold  = s && !f;
    issue = v && (op != NONE) && !s && !f;
    wr = 1'b0; ill = 1'b0; nv = '0;
    if (issue) begin
      old = ref_mem[a];
      foreach (pend[i]) if (pend[i].addr == a) old = pend[i].data;
      imm   = (op == RWI) || (op == RSI) || (op == RCI);
      src   = imm ? {27'd0, z} : rs1;
      nosrc = imm ? (z == 5'd0) : x0;
      if (op == RW || op == RWI) begin nv = src; wr = 1'b1; end
      else if (op == RS || op == RSI) begin nv = old | src; wr = !nosrc; end
      else begin nv = old & ~src; wr = !nosrc; end
      ill = (a[9:8] > pv) || (wr && a[11:10] == 2'b11);
      exp_out.push_back('{ill, ill ? 32'd0 : old});
    end
    if (!hold && pend.size() > 0 && pend[0].age == DEPTH - 1) begin
      exp_cmt.push_back('{pend[0].addr, pend[0].data});
      ref_mem[pend[0].addr] = pend[0].data;
      void'(pend.pop_front());
    end
    if (f) pend.delete();
    else if (!hold) begin
      foreach (pend[i]) pend[i].age++;
      if (issue && wr && !ill) pend.push_back('{a, nv, 0});
    end
  endtask

  task automatic iss(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                     input logic [4:0] z, input logic x0, input logic [1:0] pv);
    step(1'b0, 1'b0, 1'b0, 1'b1, op, a, rs1, z, x0, pv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, NONE, 12'h0, 32'h0, 5'd0, 1'b0, PRIV_M);
  endtask

  // Results held across a stall edge are the same result, not a new one.
  bit   prev_hold;
  out_t mo;
  cmt_t mc;
  always @(posedge clk) prev_hold <= (rst !== 1'b1) && (stall === 1'b1) && (flush !== 1'b1);

  always @(negedge clk) begin
    if (out_valid === 1'b1 && !prev_hold) begin
      if (exp_out.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL out_unexpected: got result old=%h, want none", out_old);
      end else begin
        mo = exp_out.pop_front();
        check32("out_illegal", {31'd0, out_illegal}, {31'd0, mo.ill});
        check32("out_old", out_old, mo.old);
      end
    end
    if (file_wen === 1'b1) begin
      if (exp_cmt.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL commit_unexpected: got %h<=%h, want no commit", file_waddr, file_wdata);
      end else begin
        mc = exp_cmt.pop_front();
        check32("commit_addr", {20'd0, file_waddr}, {20'd0, mc.a});
        check32("commit_data", file_wdata, mc.d);
      end
    end
  end

  logic [11:0] addrs [8] = '{12'h340, 12'h300, 12'h305, 12'h100, 12'h141, 12'h001, 12'hC00, 12'hD01};
  logic [1:0]  privs [3] = '{PRIV_U, PRIV_S, PRIV_M};

  initial begin
    logic        r, s, f, v, x0;
    logic [2:0]  op;
    logic [11:0] a;
    logic [31:0] rs1;
    logic [4:0]  z;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = NONE; in_addr = '0;
    in_rs1 = '0; in_zimm = '0; in_rs1_is_x0 = 1'b0; in_rd_is_x0 = 1'b0; priv = PRIV_M;
    step(1'b1, 1'b0, 1'b0, 1'b0, NONE, 12'h0, 32'h0, 5'd0, 1'b0, PRIV_M);
    step(1'b1, 1'b0, 1'b0, 1'b1, RW, 12'h340, 32'h1, 5'd0, 1'b0, PRIV_M);
    @(negedge clk);
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check32("rst_out_old", out_old, 32'd0);
    check32("rst_file_wen", {31'd0, file_wen}, 32'd0);

    // back-to-back RW then RS on one CSR
    iss(RW, 12'h340, 32'hAAAA5555, 5'd0, 1'b0, PRIV_M);
    iss(RS, 12'h340, 32'h0000000F, 5'd0, 1'b0, PRIV_M);
    idle(DEPTH + 1);
    check32("file_340", file_mem[12'h340], 32'hAAAA555F);
    // three immediate writes then a read must see the youngest
    iss(RWI, 12'h300, 32'h0, 5'd1, 1'b0, PRIV_M);
    iss(RWI, 12'h300, 32'h0, 5'd2, 1'b0, PRIV_M);
    iss(RWI, 12'h300, 32'h0, 5'd3, 1'b0, PRIV_M);
    iss(RS,  12'h300, 32'h0, 5'd0, 1'b1, PRIV_M);
    idle(DEPTH + 1);
    check32("file_300", file_mem[12'h300], 32'd3);
    // pure read, privilege and read-only legality
    iss(RS, 12'h305, 32'h0, 5'd0, 1'b1, PRIV_M);
    iss(RW, 12'h300, 32'h5, 5'd0, 1'b0, PRIV_U);
    iss(RW, 12'hC00, 32'h7, 5'd0, 1'b0, PRIV_M);
    iss(RS, 12'hC00, 32'h0, 5'd0, 1'b1, PRIV_M);
    idle(DEPTH + 1);
    check32("file_305_untouched", {31'd0, file_written[12'h305]}, 32'd0);
    // write reaches the commit slot, then three stall cycles
    iss(RW, 12'h341, 32'h12345678, 5'd0, 1'b0, PRIV_M);
    idle(DEPTH - 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, RW, 12'h342, 32'h9, 5'd0, 1'b0, PRIV_M);
    idle(DEPTH + 1);
    // full queue flushed; only the oldest commits, flush-cycle issue dropped
    for (int i = 0; i < DEPTH; i++) iss(RW, 12'h342 + 12'(i), 32'h100 + 32'(i), 5'd0, 1'b0, PRIV_M);
    step(1'b0, 1'b1, 1'b1, 1'b1, RW, 12'h346, 32'hDEAD, 5'd0, 1'b0, PRIV_M);
    idle(DEPTH + 1);
    check32("file_343_flushed", {31'd0, file_written[12'h343]}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 5) == 0);
      f   = ($urandom_range(0, 11) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 6));
      a   = addrs[$urandom_range(0, 7)];
      x0  = ($urandom_range(0, 3) == 0);
      rs1 = (x0 || $urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      z   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, s, f, v, op, a, rs1, z, x0, privs[$urandom_range(0, 2)]);
    end
    idle(DEPTH + 3);
    @(negedge clk);
    #1;
    check32("results_pending", 32'(exp_out.size()), 32'd0);
    check32("commits_pending", 32'(exp_cmt.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
